// File: rtl/ft232h_rx.sv
// FT232H 245 synchronous-FIFO receive engine: drains host bytes into a FWFT
// buffer, streams them out on valid/ready and checks an incrementing pattern.
module ft232h_rx #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              rxf_n,
    input  logic              txe_n,
    inout  wire  [7:0]        data,
    output logic              oe_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              siwu_n,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  rx_count,
    output logic [15:0]       err_count
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam logic [LVL_W-1:0] HIGH_MARK = LVL_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        READ = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                oe_n_q, oe_n_d;
    logic                rd_n_q, rd_n_d;

    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                valid_q, valid_d;

    logic [CNT_W-1:0]    rx_count_q, rx_count_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                seeded_q, seeded_d;
    logic [7:0]          exp_q, exp_d;

    logic [7:0]          rx_byte;
    logic                push;
    logic                pop;
    logic                unused_txe;

    // The bus is only ever sampled; this block never drives it.
    assign data       = 8'bzzzz_zzzz;
    assign rx_byte    = data;
    assign unused_txe = txe_n;

    assign wr_n      = 1'b1;
    assign siwu_n    = 1'b1;
    assign oe_n      = oe_n_q;
    assign rd_n      = rd_n_q;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = valid_q;
    assign level     = level_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;

    // A byte is taken whenever the strobe is already low and the host still has data.
    assign push = ~rd_n_q & ~rxf_n;
    assign pop  = valid_q & out_ready;

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        valid_d  = (level_d != '0);
    end

    // Read FSM: stop reading with one slot still free so the buffer cannot overflow
    always_comb begin
        state_d = state_q;
        oe_n_d  = oe_n_q;
        rd_n_d  = rd_n_q;
        unique case (state_q)
            IDLE: begin
                if (!rxf_n && (level_q < HIGH_MARK)) begin
                    state_d = OE;
                    oe_n_d  = 1'b0;
                end
            end
            OE: begin
                state_d = READ;
                rd_n_d  = 1'b0;
            end
            READ: begin
                if (rxf_n || (level_d >= HIGH_MARK)) begin
                    state_d = IDLE;
                    rd_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rd_n_d  = 1'b1;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    // Counters and incrementing-pattern checker; a mismatch re-syncs to the new byte
    always_comb begin
        rx_count_d  = rx_count_q + CNT_W'(push);
        err_count_d = err_count_q;
        seeded_d    = seeded_q;
        exp_d       = exp_q;
        if (push) begin
            seeded_d = 1'b1;
            exp_d    = rx_byte + 8'd1;
            if (seeded_q && (rx_byte != exp_q) && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            oe_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            seeded_q    <= 1'b0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            oe_n_q      <= oe_n_d;
            rd_n_q      <= rd_n_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            seeded_q    <= seeded_d;
            exp_q       <= exp_d;
        end
    end

    // Storage array carries no reset; stale entries sit behind the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (rst_n) begin
            assert (!(push && !pop && (level_q == FULL_LVL)))
                else $error("ft232h_rx: receive FIFO overflow");
        end
    end
`endif

endmodule

// File: tb/tb_ft232h_rx.sv
// Bench for ft232h_rx: FT232H host model, queue-based reference buffer and
// pattern checker compared every cycle, plus directed literal checks.
module tb_ft232h_rx;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 32;

    logic              clock;
    logic              rst_n;
    logic              rxf_n;
    logic              txe_n;
    wire  [7:0]        data;
    logic              oe_n;
    logic              rd_n;
    logic              wr_n;
    logic              siwu_n;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   level;
    logic [CNT_W-1:0]  rx_count;
    logic [15:0]       err_count;

    logic [7:0]        host_byte;
    byte unsigned      host_q[$];
    bit                hold;

    byte unsigned      mq[$];
    byte unsigned      deliv[$];
    int unsigned       m_rx;
    int unsigned       m_err;
    bit                m_seeded;
    byte unsigned      m_exp;
    bit                cap_seen;
    bit                pop_seen;

    int                n_checks;
    int                n_fail;
    byte unsigned      next_b;

    ft232h_rx #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .rxf_n     (rxf_n),
        .txe_n     (txe_n),
        .data      (data),
        .oe_n      (oe_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .siwu_n    (siwu_n),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .rx_count  (rx_count),
        .err_count (err_count)
    );

    // Host drives the bus only while the engine enables its outputs.
    assign data = oe_n ? 8'hzz : host_byte;

    initial clock = 1'b0;
    always #8 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: replay the previous edge's handshakes, then compare.
    always @(negedge clock) begin
        byte unsigned b;
        if (pop_seen && mq.size() != 0) begin
            deliv.push_back(mq.pop_front());
        end
        if (cap_seen && host_q.size() != 0) begin
            b = host_q.pop_front();
            mq.push_back(b);
            m_rx++;
            if (m_seeded && b != m_exp && m_err < 32'hFFFF) m_err++;
            m_seeded = 1'b1;
            m_exp    = 8'(b + 8'd1);
        end
        if (!rst_n) begin
            mq.delete();
            m_rx     = 0;
            m_err    = 0;
            m_seeded = 1'b0;
        end

        check("level", 64'(level), 64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) check("out_data", 64'(out_data), 64'(mq[0]));
        check("rx_count", 64'(rx_count), 64'(m_rx));
        check("err_count", 64'(err_count), 64'(m_err));
        check("level_bound", 64'(level <= 5'd15), 64'(1));
        check("rd_without_oe", 64'(!rd_n && oe_n), 64'(0));
        check("wr_siwu_high", 64'({wr_n, siwu_n}), 64'(2'b11));

        rxf_n     = hold || (host_q.size() == 0);
        host_byte = (host_q.size() != 0) ? 8'(host_q[0]) : 8'h00;
        cap_seen  = rst_n && !rd_n && !rxf_n;
        pop_seen  = rst_n && out_ready && (mq.size() != 0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((host_q.size() != 0 || level != 0) && guard < 600) begin
            tick();
            guard++;
        end
        check(name, 64'(guard < 600), 64'(1));
        repeat (2) tick();
    endtask

    task automatic check_order(input string name, input int n);
        bit ok;
        ok = (deliv.size() == n);
        for (int i = 0; i < deliv.size(); i++) begin
            if (deliv[i] != 8'(i)) ok = 1'b0;
        end
        check(name, 64'(ok), 64'(1));
    endtask

    initial begin
        int guard;
        byte unsigned t4_bytes[8];
        t4_bytes = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h07, 8'h08};
        n_checks = 0;
        n_fail   = 0;
        next_b   = 8'h00;
        rst_n    = 1'b1;
        rxf_n    = 1'b1;
        txe_n    = 1'b1;
        hold     = 1'b0;
        out_ready = 1'b0;
        host_byte = 8'h00;
        cap_seen = 1'b0;
        pop_seen = 1'b0;
        m_rx = 0; m_err = 0; m_seeded = 1'b0; m_exp = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        check("rst_oe_n", 64'(oe_n), 64'(1));
        check("rst_rd_n", 64'(rd_n), 64'(1));
        check("rst_level", 64'(level), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_rx_count", 64'(rx_count), 64'(0));

        // T1: five bytes, first capture on the third edge
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin host_q.push_back(next_b); next_b++; end
        tick();
        check("t1_e1_oe_n", 64'(oe_n), 64'(0));
        check("t1_e1_rd_n", 64'(rd_n), 64'(1));
        tick();
        check("t1_e2_rd_n", 64'(rd_n), 64'(0));
        check("t1_e2_cnt", 64'(rx_count), 64'(0));
        for (int k = 3; k <= 7; k++) begin
            tick();
            check("t1_cnt", 64'(rx_count), 64'(k - 2));
        end
        tick();
        check("t1_end_rd_n", 64'(rd_n), 64'(1));
        check("t1_end_oe_n", 64'(oe_n), 64'(1));
        drain("t1_drain");
        check("t1_err", 64'(err_count), 64'(0));
        check_order("t1_order", 5);

        // T2: backpressure stops reads with one slot free, then drains in order
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin host_q.push_back(next_b); next_b++; end
        guard = 0;
        while (level != 15 && guard < 200) begin tick(); guard++; end
        check("t2_reach_15", 64'(level), 64'(15));
        check("t2_rd_n_stop", 64'(rd_n), 64'(1));
        check("t2_cnt_20", 64'(rx_count), 64'(20));
        repeat (4) tick();
        check("t2_hold_15", 64'(level), 64'(15));
        check("t2_oe_n_idle", 64'(oe_n), 64'(1));
        out_ready = 1'b1;
        drain("t2_drain");
        check("t2_cnt_45", 64'(rx_count), 64'(45));
        check_order("t2_order", 45);

        // T3: one-cycle rxf_n gap in the middle of a burst
        for (int i = 0; i < 20; i++) begin host_q.push_back(next_b); next_b++; end
        guard = 0;
        while (rd_n != 1'b0 && guard < 50) begin tick(); guard++; end
        check("t3_reading", 64'(rd_n), 64'(0));
        tick();
        hold = 1'b1;
        tick();
        hold = 1'b0;
        check("t3_gap_rd_n", 64'(rd_n), 64'(1));
        check("t3_gap_oe_n", 64'(oe_n), 64'(1));
        tick();
        check("t3_reenter_oe_n", 64'(oe_n), 64'(0));
        check("t3_reenter_rd_n", 64'(rd_n), 64'(1));
        tick();
        check("t3_resume_rd_n", 64'(rd_n), 64'(0));
        drain("t3_drain");
        check("t3_cnt_65", 64'(rx_count), 64'(65));
        check_order("t3_order", 65);

        // T5: steady push and pop together at level 8
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin host_q.push_back(next_b); next_b++; end
        guard = 0;
        while (level != 8 && guard < 100) begin tick(); guard++; end
        check("t5_reach_8", 64'(level), 64'(8));
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_level_8", 64'(level), 64'(8));
        end
        drain("t5_drain");
        check("t5_cnt_105", 64'(rx_count), 64'(105));
        check("t5_err", 64'(err_count), 64'(0));
        check_order("t5_order", 105);

        // T6: asynchronous reset while reading
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin host_q.push_back(next_b); next_b++; end
        guard = 0;
        while (level != 6 && guard < 100) begin tick(); guard++; end
        check("t6_reach_6", 64'(level), 64'(6));
        check("t6_in_read", 64'(rd_n), 64'(0));
        rst_n = 1'b0;
        host_q.delete();
        deliv.delete();
        #1;
        check("t6_oe_n", 64'(oe_n), 64'(1));
        check("t6_rd_n", 64'(rd_n), 64'(1));
        check("t6_level", 64'(level), 64'(0));
        check("t6_valid", 64'(out_valid), 64'(0));
        check("t6_rx_count", 64'(rx_count), 64'(0));
        check("t6_err", 64'(err_count), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // T4: wrap-around is clean, one jump counts once and re-seeds
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) host_q.push_back(t4_bytes[i]);
        drain("t4a_drain");
        check("t4a_err", 64'(err_count), 64'(0));
        check("t4a_cnt", 64'(rx_count), 64'(5));
        for (int i = 5; i < 8; i++) host_q.push_back(t4_bytes[i]);
        drain("t4b_drain");
        check("t4b_err", 64'(err_count), 64'(1));
        check("t4b_cnt", 64'(rx_count), 64'(8));
        check("t4_deliv_n", 64'(deliv.size()), 64'(8));
        for (int i = 0; i < 8 && i < deliv.size(); i++) begin
            check("t4_deliv", 64'(deliv[i]), 64'(t4_bytes[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
